key_event_conditioner: RTL and testbench



---
 rtl/key_event_conditioner.sv | 197 +++++++++++++++++++
 tb/tb_key_event_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_conditioner.sv
// Synchronise, debounce and classify the active-low DE2-115 pushbuttons feeding the PIO.
// Define AUTO_REPEAT_EN to add per-key auto-repeat pulses while a key is held.
module key_event_conditioner #(
  parameter int unsigned NUM_KEYS          = 3,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned REPEAT_CYCLES     = 10000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key_n,
  output logic [NUM_KEYS-1:0]   key_level_n,
  output logic [NUM_KEYS-1:0]   press_pulse,
  output logic [NUM_KEYS-1:0]   release_pulse,
  output logic [NUM_KEYS-1:0]   long_pulse,
  output logic [NUM_KEYS-1:0]   repeat_pulse,
  output logic [3*NUM_KEYS-1:0] event_flags,
  input  logic [3*NUM_KEYS-1:0] event_clr
);

  localparam int unsigned   DCW       = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned   HCW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HCNT_LAST = HCW'(LONG_PRESS_CYCLES - 1);
  // hcnt stops at LONG_PRESS_CYCLES once the long event fired; that value marks "long issued".
  localparam logic [HCW-1:0] HCNT_DONE = HCW'(LONG_PRESS_CYCLES);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 2) begin : g_param_check
    $error("key_event_conditioner: illegal parameter set");
  end

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    HELD,
    RELEASE_CHK
  } key_state_t;

  logic [SYNC_STAGES-1:0] sync_q  [NUM_KEYS];
  key_state_t             state_q [NUM_KEYS];
  key_state_t             state_d [NUM_KEYS];
  logic [DCW-1:0]         dcnt_q  [NUM_KEYS];
  logic [DCW-1:0]         dcnt_d  [NUM_KEYS];
  logic [HCW-1:0]         hcnt_q  [NUM_KEYS];
  logic [HCW-1:0]         hcnt_d  [NUM_KEYS];
  logic [NUM_KEYS-1:0]    key_s;
  logic [NUM_KEYS-1:0]    level_d;
  logic [NUM_KEYS-1:0]    press_d;
  logic [NUM_KEYS-1:0]    release_d;
  logic [NUM_KEYS-1:0]    long_d;
  logic [NUM_KEYS-1:0]    repeat_d;
  logic [3*NUM_KEYS-1:0]  flags_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned    RCW       = $clog2(REPEAT_CYCLES);
  localparam logic [RCW-1:0] RCNT_LAST = RCW'(REPEAT_CYCLES - 1);
  logic [RCW-1:0] rcnt_q [NUM_KEYS];
  logic [RCW-1:0] rcnt_d [NUM_KEYS];
`endif

  always_comb begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      key_s[k] = sync_q[k][SYNC_STAGES-1];
    end
  end

  always_comb begin
    level_d   = key_level_n;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    repeat_d  = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      state_d[k] = state_q[k];
      dcnt_d[k]  = dcnt_q[k];
      hcnt_d[k]  = hcnt_q[k];
`ifdef AUTO_REPEAT_EN
      rcnt_d[k]  = rcnt_q[k];
`endif
      case (state_q[k])
        RELEASED: begin
`ifdef AUTO_REPEAT_EN
          rcnt_d[k] = '0;
`endif
          if (!key_s[k]) begin
            state_d[k] = PRESS_CHK;
            dcnt_d[k]  = '0;
          end
        end
        PRESS_CHK: begin
          if (key_s[k]) begin
            state_d[k] = RELEASED;
          end else if (dcnt_q[k] == DCNT_LAST) begin
            state_d[k] = PRESSED;
            press_d[k] = 1'b1;
            level_d[k] = 1'b0;
            hcnt_d[k]  = '0;
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end
        PRESSED: begin
          hcnt_d[k] = hcnt_q[k] + 1'b1;
          // Long press wins over a release seen on the same cycle; HELD picks the release up next.
          if (hcnt_q[k] == HCNT_LAST) begin
            state_d[k] = HELD;
            long_d[k]  = 1'b1;
          end else if (key_s[k]) begin
            state_d[k] = RELEASE_CHK;
            dcnt_d[k]  = '0;
          end
        end
        HELD: begin
          if (key_s[k]) begin
            state_d[k] = RELEASE_CHK;
            dcnt_d[k]  = '0;
          end
`ifdef AUTO_REPEAT_EN
          if (rcnt_q[k] == RCNT_LAST) begin
            rcnt_d[k]   = '0;
            repeat_d[k] = 1'b1;
          end else begin
            rcnt_d[k] = rcnt_q[k] + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (!key_s[k]) begin
            state_d[k] = (hcnt_q[k] == HCNT_DONE) ? HELD : PRESSED;
          end else if (dcnt_q[k] == DCNT_LAST) begin
            state_d[k]   = RELEASED;
            release_d[k] = 1'b1;
            level_d[k]   = 1'b1;
`ifdef AUTO_REPEAT_EN
            rcnt_d[k]    = '0;
`endif
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end
        default: state_d[k] = RELEASED;
      endcase
    end
    // A set on the same cycle as its clear wins.
    flags_d = (event_flags & ~event_clr) | {long_d, release_d, press_d | repeat_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        sync_q[k]  <= '1;
        state_q[k] <= RELEASED;
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
      end
      key_level_n   <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      event_flags   <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        sync_q[k]  <= {sync_q[k][SYNC_STAGES-2:0], key_n[k]};
        state_q[k] <= state_d[k];
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
      end
      key_level_n   <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      event_flags   <= flags_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        rcnt_q[k] <= '0;
      end
      repeat_pulse <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        rcnt_q[k] <= rcnt_d[k];
      end
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_key_event_conditioner.sv
// Directed bench for key_event_conditioner: pulse events are scoreboarded by expected edge,
// levels and flags are checked inline at fixed points.
module tb_key_event_conditioner;

  localparam int NK = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level_n;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] long_pulse;
  logic [NK-1:0] repeat_pulse;
  logic [3*NK-1:0] event_flags;
  logic [3*NK-1:0] event_clr;

  int compared   = 0;
  int mismatched = 0;
  int edge_n     = 0;
  logic mon_en   = 1'b0;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  ev_t exp_q[$];
  logic [4*NK-1:0] pulses_v;
  string kind_name[4] = '{"press", "release", "long", "repeat"};

  key_event_conditioner #(
    .NUM_KEYS(3),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .key_level_n(key_level_n),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .event_flags(event_flags),
    .event_clr(event_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  assign pulses_v = {repeat_pulse, long_pulse, release_pulse, press_pulse};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int key, input int cyc);
    ev_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.key  = key;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all;
    event_clr = '1;
    wait_edge(edge_n + 1);
    event_clr = '0;
  endtask

  // Every observed pulse must match a queued expectation for that kind/key at this edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int kind = 0; kind < 4; kind++) begin
        for (int k = 0; k < NK; k++) begin
          if (pulses_v[kind*NK+k] !== 1'b0) begin
            int idx;
            int exp_cyc;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (idx < 0 && exp_q[i].kind == kind && exp_q[i].key == k) idx = i;
            end
            exp_cyc = (idx >= 0) ? exp_q[idx].cyc : -1;
            compared++;
            assert (edge_n === exp_cyc) else begin
              mismatched++;
              $error("FAIL pulse_%s key %0d: observed at edge %0d, expected edge %0d (-1 = none)",
                     kind_name[kind], k, edge_n, exp_cyc);
            end
            if (idx >= 0) exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int r;

    reset     = 1'b1;
    key_n     = 3'b111;
    event_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", key_level_n, 3'b111);
    chk("reset_flags", event_flags, 9'h000);
    chk("reset_pulses", pulses_v, 12'h000);
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_edge(edge_n + 3);

    // Clean press and release of key 0.
    t = edge_n + 1;
    key_n = 3'b110;
    expect_ev(0, 0, t + 6);
    wait_edge(t + 5);
    chk("press_latency_level_before", key_level_n, 3'b111);
    wait_edge(t + 6);
    chk("press_level", key_level_n, 3'b110);
    chk("press_flag", event_flags, 9'h001);
    wait_edge(t + 9);
    r = edge_n + 1;
    key_n = 3'b111;
    expect_ev(1, 0, r + 6);
    wait_edge(r + 5);
    chk("release_level_before", key_level_n, 3'b110);
    wait_edge(r + 6);
    chk("release_level", key_level_n, 3'b111);
    chk("release_flags", event_flags, 9'h009);

    // Write-1-to-clear, one bit at a time.
    event_clr = 9'h001;
    wait_edge(edge_n + 1);
    event_clr = 9'h000;
    chk("clear_press_flag", event_flags, 9'h008);
    event_clr = 9'h008;
    wait_edge(edge_n + 1);
    event_clr = 9'h000;
    chk("clear_release_flag", event_flags, 9'h000);

    // Key 1 low for DEBOUNCE_CYCLES samples only: rejected.
    t = edge_n + 1;
    key_n = 3'b101;
    wait_edge(t + 3);
    key_n = 3'b111;
    wait_edge(t + 12);
    chk("bounce_level", key_level_n, 3'b111);
    chk("bounce_flags", event_flags, 9'h000);

    // Key 1 low for DEBOUNCE_CYCLES+1 samples: shortest accepted press.
    t = edge_n + 1;
    key_n = 3'b101;
    expect_ev(0, 1, t + 6);
    expect_ev(1, 1, t + 11);
    wait_edge(t + 4);
    key_n = 3'b111;
    wait_edge(t + 11);
    chk("min_press_level", key_level_n, 3'b111);
    chk("min_press_flags", event_flags, 9'h012);
    clear_all();
    wait_edge(edge_n + 3);

    // Key 1 pressed, 2-cycle release bounce, then reset while still in PRESSED.
    t = edge_n + 1;
    key_n = 3'b101;
    expect_ev(0, 1, t + 6);
    wait_edge(t + 8);
    key_n = 3'b111;
    wait_edge(t + 10);
    key_n = 3'b101;
    wait_edge(t + 20);
    chk("release_bounce_level", key_level_n, 3'b101);
    chk("release_bounce_flags", event_flags, 9'h002);
    reset = 1'b1;
    wait_edge(t + 21);
    chk("midreset_level", key_level_n, 3'b111);
    chk("midreset_flags", event_flags, 9'h000);
    chk("midreset_pulses", pulses_v, 12'h000);
    reset = 1'b0;
    t = edge_n + 1;
    expect_ev(0, 1, t + 6);
    wait_edge(t + 6);
    chk("repress_level", key_level_n, 3'b101);
    wait_edge(t + 7);
    r = edge_n + 1;
    key_n = 3'b111;
    expect_ev(1, 1, r + 6);
    wait_edge(r + 6);
    chk("rerelease_level", key_level_n, 3'b111);
    clear_all();
    wait_edge(edge_n + 3);

    // Long press on key 2 held for 40 samples.
    t = edge_n + 1;
    key_n = 3'b011;
    expect_ev(0, 2, t + 6);
    expect_ev(2, 2, t + 26);
`ifdef AUTO_REPEAT_EN
    expect_ev(3, 2, t + 34);
    expect_ev(3, 2, t + 42);
`endif
    wait_edge(t + 25);
    chk("long_flags_before", event_flags, 9'h004);
    wait_edge(t + 26);
    chk("long_flags", event_flags, 9'h104);
    wait_edge(t + 39);
    r = edge_n + 1;
    key_n = 3'b111;
    expect_ev(1, 2, r + 6);
    wait_edge(r + 6);
    chk("long_release_level", key_level_n, 3'b111);
    chk("long_release_flags", event_flags, 9'h124);
    clear_all();
    wait_edge(edge_n + 3);

    // Keys 0 and 2 together; clear of the press flags coincides with the press pulse.
    t = edge_n + 1;
    key_n = 3'b010;
    expect_ev(0, 0, t + 6);
    expect_ev(0, 2, t + 6);
    wait_edge(t + 5);
    event_clr = 9'h005;
    wait_edge(t + 6);
    event_clr = 9'h000;
    chk("set_beats_clear", event_flags, 9'h005);
    chk("dual_press_level", key_level_n, 3'b010);
    event_clr = 9'h001;
    wait_edge(edge_n + 1);
    event_clr = 9'h000;
    chk("clear_one_of_two", event_flags, 9'h004);
    r = edge_n + 1;
    key_n = 3'b111;
    expect_ev(1, 0, r + 6);
    expect_ev(1, 2, r + 6);
    wait_edge(r + 6);
    chk("dual_release_level", key_level_n, 3'b111);
    chk("dual_release_flags", event_flags, 9'h02C);

    wait_edge(edge_n + 10);
    chk("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
